// File: rtl/traffic_pkg.sv
// Shared types and defaults for the highway/farm-road light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_HG = 2'b00,
    S_HY = 2'b01,
    S_FG = 2'b10,
    S_FY = 2'b11
  } state_e;

  localparam int unsigned TL_CYCLES_DEF = 8;
  localparam int unsigned TS_CYCLES_DEF = 3;

  typedef struct packed {
    logic hg;
    logic hy;
    logic hr;
    logic fg;
    logic fy;
    logic fr;
  } lamps_t;

  // One highway lamp and one farm lamp per state.
  function automatic lamps_t lamp_decode(input state_e s);
    lamps_t l;
    l = '0;
    case (s)
      S_HG: begin l.hg = 1'b1; l.fr = 1'b1; end
      S_HY: begin l.hy = 1'b1; l.fr = 1'b1; end
      S_FG: begin l.hr = 1'b1; l.fg = 1'b1; end
      S_FY: begin l.hr = 1'b1; l.fy = 1'b1; end
      default: begin l.hg = 1'b1; l.fr = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_timer.sv
// Dwell timer: restarts on ST, saturates at TL_CYCLES-1, flags short/long expiry.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TL_CYCLES = TL_CYCLES_DEF,
  parameter int unsigned TS_CYCLES = TS_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ST,
  output logic TS,
  output logic TL
);

  localparam int unsigned CW = $clog2(TL_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TL_CYCLES - 1);
  localparam logic [CW-1:0] TS_THR  = CW'(TS_CYCLES - 1);
  localparam logic TS_AT_ZERO = (TS_CYCLES <= 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (ST) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  // TS/TL are registered from the next count so they line up with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      TS  <= TS_AT_ZERO;
      TL  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      TS  <= (cnt_nxt >= TS_THR);
      TL  <= (cnt_nxt >= CNT_MAX);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Highway/farm-road light controller: Moore FSM with dwell timer.
// Define TRAFFIC_C_SYNC_EN to pass the car sensor through a two-flop synchronizer.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TL_CYCLES = TL_CYCLES_DEF,
  parameter int unsigned TS_CYCLES = TS_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic C,
  output logic HG,
  output logic HY,
  output logic HR,
  output logic FG,
  output logic FY,
  output logic FR,
  output logic ST
);

  logic   c_use;
  logic   ts;
  logic   tl;
  state_e state;
  state_e state_nxt;
  lamps_t lamps;

`ifdef TRAFFIC_C_SYNC_EN
  logic [1:0] c_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_sync <= 2'b00;
    end else begin
      c_sync <= {c_sync[0], C};
    end
  end

  assign c_use = c_sync[1];
`else
  assign c_use = C;
`endif

  traffic_timer #(
    .TL_CYCLES(TL_CYCLES),
    .TS_CYCLES(TS_CYCLES)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .ST (ST),
    .TS (ts),
    .TL (tl)
  );

  // Transition conditions; ST marks the cycle a transition is taken.
  always_comb begin
    state_nxt = state;
    ST        = 1'b0;
    if (!rst) begin
      unique case (state)
        S_HG: if (c_use && tl)  begin state_nxt = S_HY; ST = 1'b1; end
        S_HY: if (ts)           begin state_nxt = S_FG; ST = 1'b1; end
        S_FG: if (!c_use || tl) begin state_nxt = S_FY; ST = 1'b1; end
        S_FY: if (ts)           begin state_nxt = S_HG; ST = 1'b1; end
      endcase
    end
  end

  // Lamps are registered alongside the state, so they always match it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_HG;
      lamps <= lamp_decode(S_HG);
    end else begin
      state <= state_nxt;
      lamps <= lamp_decode(state_nxt);
    end
  end

  assign HG = lamps.hg;
  assign HY = lamps.hy;
  assign HR = lamps.hr;
  assign FG = lamps.fg;
  assign FY = lamps.fy;
  assign FR = lamps.fr;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed and random-invariant bench for traffic_light_ctrl (direct C, default timing).
module tb_traffic_light_ctrl;

  localparam logic [5:0] L_HG = 6'b100_001;
  localparam logic [5:0] L_HY = 6'b010_001;
  localparam logic [5:0] L_FG = 6'b001_100;
  localparam logic [5:0] L_FY = 6'b001_010;

  logic clk = 1'b0;
  logic rst;
  logic C;
  logic HG, HY, HR, FG, FY, FR, ST;
  logic [5:0] lamps;

  int n_cmp = 0;
  int n_err = 0;

  assign lamps = {HG, HY, HR, FG, FY, FR};

  always #5 clk = ~clk;

  traffic_light_ctrl dut (
    .clk(clk),
    .rst(rst),
    .C  (C),
    .HG (HG),
    .HY (HY),
    .HR (HR),
    .FG (FG),
    .FY (FY),
    .FR (FR),
    .ST (ST)
  );

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of cycle 0 (first cycle after the reset edge).
  task automatic do_reset(input logic c0);
    @(negedge clk);
    rst = 1'b1;
    C   = c0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    C   = 1'b1;
    #1;
    n_cmp++;
    if (ST !== 1'b0) begin
      n_err++;
      $display("FAIL reset_st_forced st=%b expected 0", ST);
    end
    next_cycle();
    rst = 1'b0;
    C   = 1'b0;
    for (int k = 0; k < 50; k++) begin
      #1;
      n_cmp++;
      if ({lamps, ST} !== {L_HG, 1'b0}) begin
        n_err++;
        $display("FAIL reset_idle cycle=%0d lamps=%b st=%b expected lamps=%b st=0", k, lamps, ST, L_HG);
      end
      next_cycle();
    end
  endtask

  task automatic test_car_waiting();
    logic [5:0] el;
    logic       es;
    do_reset(1'b1);
    for (int k = 0; k < 26; k++) begin
      if (k <= 7)       el = L_HG;
      else if (k <= 10) el = L_HY;
      else if (k <= 18) el = L_FG;
      else if (k <= 21) el = L_FY;
      else              el = L_HG;
      es = (k == 7) || (k == 10) || (k == 18) || (k == 21);
      #1;
      n_cmp++;
      if ({lamps, ST} !== {el, es}) begin
        n_err++;
        $display("FAIL car_waiting cycle=%0d lamps=%b st=%b expected lamps=%b st=%b", k, lamps, ST, el, es);
      end
      next_cycle();
    end
  endtask

  task automatic test_short_pulse();
    do_reset(1'b0);
    for (int k = 0; k < 21; k++) begin
      C = (k >= 2) && (k <= 4);
      #1;
      n_cmp++;
      if ({lamps, ST} !== {L_HG, 1'b0}) begin
        n_err++;
        $display("FAIL short_pulse cycle=%0d lamps=%b st=%b expected lamps=%b st=0", k, lamps, ST, L_HG);
      end
      next_cycle();
    end
  endtask

  task automatic test_car_leaves();
    logic [5:0] el;
    logic       es;
    do_reset(1'b1);
    for (int k = 0; k < 22; k++) begin
      C = (k < 13);
      if (k <= 7)       el = L_HG;
      else if (k <= 10) el = L_HY;
      else if (k <= 13) el = L_FG;
      else if (k <= 16) el = L_FY;
      else              el = L_HG;
      es = (k == 7) || (k == 10) || (k == 13) || (k == 16);
      #1;
      n_cmp++;
      if ({lamps, ST} !== {el, es}) begin
        n_err++;
        $display("FAIL car_leaves cycle=%0d lamps=%b st=%b expected lamps=%b st=%b", k, lamps, ST, el, es);
      end
      next_cycle();
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] el;
    logic       es;
    do_reset(1'b1);
    for (int k = 0; k < 15; k++) next_cycle();
    #1;
    n_cmp++;
    if ({lamps, ST} !== {L_FG, 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset_pre lamps=%b st=%b expected lamps=%b st=0", lamps, ST, L_FG);
    end
    rst = 1'b1;
    C   = 1'b0;
    #1;
    n_cmp++;
    if (ST !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_st_forced st=%b expected 0", ST);
    end
    next_cycle();
    rst = 1'b0;
    C   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      el = (k <= 7) ? L_HG : L_HY;
      es = (k == 7);
      #1;
      n_cmp++;
      if ({lamps, ST} !== {el, es}) begin
        n_err++;
        $display("FAIL mid_reset_post cycle=%0d lamps=%b st=%b expected lamps=%b st=%b", k, lamps, ST, el, es);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [5:0] prev_l;
    logic [5:0] cur_l;
    logic [5:0] succ;
    logic       prev_st;
    int         dwell;
    do_reset(1'b0);
    C = 1'($urandom_range(0, 1));
    #1;
    prev_l  = lamps;
    prev_st = ST;
    dwell   = 1;
    for (int i = 1; i < 512; i++) begin
      next_cycle();
      C = 1'($urandom_range(0, 1));
      #1;
      cur_l = lamps;
      n_cmp++;
      if (!($countones(cur_l[5:3]) == 1 && $countones(cur_l[2:0]) == 1 && (cur_l[3] || cur_l[0]))) begin
        n_err++;
        $display("FAIL rand_lamps cycle=%0d lamps=%b expected one lamp per road with a red", i, cur_l);
      end
      n_cmp++;
      if (prev_st !== (cur_l != prev_l)) begin
        n_err++;
        $display("FAIL rand_st cycle=%0d prev_st=%b expected %b", i, prev_st, (cur_l != prev_l));
      end
      if (cur_l != prev_l) begin
        case (prev_l)
          L_HG:    succ = L_HY;
          L_HY:    succ = L_FG;
          L_FG:    succ = L_FY;
          default: succ = L_HG;
        endcase
        n_cmp++;
        if (cur_l !== succ) begin
          n_err++;
          $display("FAIL rand_order cycle=%0d lamps=%b expected %b", i, cur_l, succ);
        end
        n_cmp++;
        if (((prev_l == L_HY || prev_l == L_FY) && dwell != 3) ||
            (prev_l == L_HG && dwell < 8) ||
            (prev_l == L_FG && (dwell < 1 || dwell > 8))) begin
          n_err++;
          $display("FAIL rand_dwell cycle=%0d state_lamps=%b dwell=%0d outside required range", i, prev_l, dwell);
        end
        dwell = 1;
      end else begin
        dwell++;
      end
      prev_l  = cur_l;
      prev_st = ST;
    end
  endtask

  initial begin
    rst = 1'b1;
    C   = 1'b0;
    test_reset();
    test_car_waiting();
    test_short_pulse();
    test_car_leaves();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
